// File: rtl/rx_decim_core.sv
// Receive decimator: 8-lane sum, accumulate-and-dump over L beats, scale/saturate, FWFT FIFO to AXI-Stream.
// Latency: 4 clock edges from the last beat of a window to tvalid; backpressure via tready, full FIFO drops results and sets overflow.
// Backpressure: upstream is never stalled; a full FIFO with no pop drops the result and sets overflow.

module rx_decim_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 16,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          wr_vld_i,
    input  logic [W-1:0]  wr_dat_i,
    output logic          wr_rdy_o,
    output logic          rd_vld_o,
    output logic [W-1:0]  rd_dat_o,
    input  logic          rd_rdy_i,
    output logic [LW-1:0] level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LW-1:0] count_q, count_d;
    logic          full, wr_en, rd_en;

    always_comb begin
        full     = (count_q == LW'(DEPTH));
        rd_vld_o = (count_q != '0);
        rd_dat_o = rd_vld_o ? mem_q[rptr_q] : '0;
        rd_en    = rd_vld_o && rd_rdy_i;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        wr_rdy_o = !full || rd_en;
        wr_en    = wr_vld_i && wr_rdy_o;
        wptr_d   = wr_en ? wptr_q + AW'(1) : wptr_q;
        rptr_d   = rd_en ? rptr_q + AW'(1) : rptr_q;
        count_d  = count_q;
        if (wr_en && !rd_en)
            count_d = count_q + LW'(1);
        else if (!wr_en && rd_en)
            count_d = count_q - LW'(1);
        level_o  = count_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en)
            mem_q[wptr_q] <= wr_dat_i;
    end
endmodule

module rx_decim_core #(
    parameter int NUMBER_OF_LINE = 8,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic                          enable,
    input  logic [16*NUMBER_OF_LINE-1:0]  adc_data,
    input  logic                          adc_valid,
    input  logic [7:0]                    decim_len,
    input  logic [4:0]                    out_shift,
    input  logic                          clear_status,
    output logic [15:0]                   m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          overflow,
    output logic [15:0]                   peak_abs,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int SUMW = 14 + $clog2(NUMBER_OF_LINE);
    localparam int ACCW = SUMW + 8;
    localparam logic signed [ACCW-1:0] SAT_MAX = 32767;
    localparam logic signed [ACCW-1:0] SAT_MIN = -32768;

    logic signed [13:0]      s1_samp_q [NUMBER_OF_LINE];
    logic signed [13:0]      s1_samp_d [NUMBER_OF_LINE];
    logic                    s1_vld_q, s1_vld_d;
    logic [NUMBER_OF_LINE-1:0] lsb_unused;

    logic [SUMW-1:0]         s2_sum_q, s2_sum_d;
    logic                    s2_vld_q, s2_vld_d;

    logic [8:0]              cnt_q, cnt_d, lw_q, lw_d, eff_len;
    logic [4:0]              shw_q, shw_d, eff_sh, sh_clamped;
    logic signed [ACCW-1:0]  acc_q, acc_d, acc_sum, sum_ext;
    logic signed [ACCW-1:0]  dump_q, dump_d, shifted;
    logic [4:0]              dump_sh_q, dump_sh_d;
    logic                    dump_vld_q, dump_vld_d;
    logic                    first_beat, close;

    logic [15:0]             result, res_abs, peak_q, peak_d;
    logic                    ovf_q, ovf_d, wr_rdy, wr_acc, wr_drop;

    // S1/S2: lane extraction and adder tree
    always_comb begin
        s1_vld_d = adc_valid && enable;
        s2_vld_d = s1_vld_q && enable;
        s2_sum_d = '0;
        for (int i = 0; i < NUMBER_OF_LINE; i++) begin
            s1_samp_d[i]  = adc_data[16*i+2 +: 14];
            lsb_unused[i] = ^adc_data[16*i +: 2];
            s2_sum_d      = s2_sum_d + {{(SUMW-14){s1_samp_q[i][13]}}, s1_samp_q[i]};
        end
    end

    // S3: window bookkeeping; a new window samples config on its first beat
    always_comb begin
        sh_clamped = (out_shift > 5'd24) ? 5'd24 : out_shift;
        first_beat = (cnt_q == '0);
        eff_len    = first_beat ? ({1'b0, decim_len} + 9'd1) : lw_q;
        eff_sh     = first_beat ? sh_clamped : shw_q;
        sum_ext    = {{(ACCW-SUMW){s2_sum_q[SUMW-1]}}, s2_sum_q};
        acc_sum    = first_beat ? sum_ext : acc_q + sum_ext;
        close      = s2_vld_q && ((cnt_q + 9'd1) == eff_len);

        cnt_d      = cnt_q;
        acc_d      = acc_q;
        lw_d       = lw_q;
        shw_d      = shw_q;
        dump_d     = dump_q;
        dump_sh_d  = dump_sh_q;
        dump_vld_d = 1'b0;
        if (!enable) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (s2_vld_q) begin
            acc_d = acc_sum;
            lw_d  = eff_len;
            shw_d = eff_sh;
            if (close) begin
                cnt_d      = '0;
                dump_d     = acc_sum;
                dump_sh_d  = eff_sh;
                dump_vld_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 9'd1;
            end
        end
    end

    // S4: scale, saturate, and status tracking on the FIFO write
    always_comb begin
        shifted = dump_q >>> dump_sh_q;
        if (shifted > SAT_MAX)
            result = 16'h7FFF;
        else if (shifted < SAT_MIN)
            result = 16'h8000;
        else
            result = shifted[15:0];
        res_abs = result[15] ? (16'd0 - result) : result;

        wr_acc  = dump_vld_q && wr_rdy;
        wr_drop = dump_vld_q && !wr_rdy;
        ovf_d   = wr_drop ? 1'b1 : (clear_status ? 1'b0 : ovf_q);
        if (clear_status)
            peak_d = wr_acc ? res_abs : 16'd0;
        else if (wr_acc && (res_abs > peak_q))
            peak_d = res_abs;
        else
            peak_d = peak_q;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUMBER_OF_LINE; i++)
                s1_samp_q[i] <= '0;
            s1_vld_q   <= 1'b0;
            s2_sum_q   <= '0;
            s2_vld_q   <= 1'b0;
            cnt_q      <= '0;
            lw_q       <= '0;
            shw_q      <= '0;
            acc_q      <= '0;
            dump_q     <= '0;
            dump_sh_q  <= '0;
            dump_vld_q <= 1'b0;
            ovf_q      <= 1'b0;
            peak_q     <= '0;
        end else begin
            for (int i = 0; i < NUMBER_OF_LINE; i++)
                s1_samp_q[i] <= s1_samp_d[i];
            s1_vld_q   <= s1_vld_d;
            s2_sum_q   <= s2_sum_d;
            s2_vld_q   <= s2_vld_d;
            cnt_q      <= cnt_d;
            lw_q       <= lw_d;
            shw_q      <= shw_d;
            acc_q      <= acc_d;
            dump_q     <= dump_d;
            dump_sh_q  <= dump_sh_d;
            dump_vld_q <= dump_vld_d;
            ovf_q      <= ovf_d;
            peak_q     <= peak_d;
        end
    end

    rx_decim_fifo #(
        .W     (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i    (clock),
        .rst_ni   (resetn),
        .wr_vld_i (dump_vld_q),
        .wr_dat_i (result),
        .wr_rdy_o (wr_rdy),
        .rd_vld_o (m_axis_tvalid),
        .rd_dat_o (m_axis_tdata),
        .rd_rdy_i (m_axis_tready),
        .level_o  (fifo_level)
    );

    assign overflow = ovf_q;
    assign peak_abs = peak_q;
endmodule

// File: tb/tb_rx_decim_core.sv
// Bench for rx_decim_core: table of decimation cases plus hand sequences for latency,
// overflow, valid gaps, config change, enable drop and mid-window reset.
module tb_rx_decim_core;
    logic         clock = 1'b0;
    logic         resetn;
    logic         enable;
    logic [127:0] adc_data;
    logic         adc_valid;
    logic [7:0]   decim_len;
    logic [4:0]   out_shift;
    logic         clear_status;
    logic [15:0]  m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         overflow;
    logic [15:0]  peak_abs;
    logic [4:0]   fifo_level;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int exp_q[$];
    int pop_cyc[$];

    typedef struct {
        logic [15:0] lane;
        int          dl;
        int          sh;
        int          nbeats;
        int          exp_data;
        int          exp_peak;
    } vec_t;
    vec_t vecs[8];

    rx_decim_core #(.NUMBER_OF_LINE(8), .FIFO_DEPTH(16)) dut (
        .clock         (clock),
        .resetn        (resetn),
        .enable        (enable),
        .adc_data      (adc_data),
        .adc_valid     (adc_valid),
        .decim_len     (decim_len),
        .out_shift     (out_shift),
        .clear_status  (clear_status),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .overflow      (overflow),
        .peak_abs      (peak_abs),
        .fifo_level    (fifo_level)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard: every accepted output word is compared against the queue head.
    always @(negedge clock) begin
        if (resetn && m_axis_tvalid && m_axis_tready) begin
            pop_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL spurious_output: got %0d, no word expected", $signed(m_axis_tdata));
            end else begin
                chk("tdata", int'($signed(m_axis_tdata)), exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [15:0] lane, input logic v);
        adc_data  = {8{lane}};
        adc_valid = v;
        tick();
        adc_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
    endtask

    task automatic drain(input int budget);
        m_axis_tready = 1'b1;
        for (int i = 0; i < budget && exp_q.size() != 0; i++)
            tick();
        repeat (3) tick();
        chk("drain_remaining", exp_q.size(), 0);
        chk("tvalid_after_drain", int'(m_axis_tvalid), 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'h0190, 3,   0,  16,  3200,   3200};
        vecs[1] = '{16'h7FFC, 255, 0,  256, 32767,  32767};
        vecs[2] = '{16'h7FFC, 255, 10, 256, 16382,  16382};
        vecs[3] = '{16'h8000, 0,   0,  8,   -32768, 32768};
        vecs[4] = '{16'hFFFC, 1,   1,  4,   -8,     8};
        vecs[5] = '{16'hFFFC, 0,   4,  3,   -1,     1};
        vecs[6] = '{16'h0004, 2,   2,  6,   6,      6};
        vecs[7] = '{16'h8000, 255, 31, 256, -1,     1};

        resetn        = 1'b0;
        enable        = 1'b0;
        adc_data      = '0;
        adc_valid     = 1'b0;
        decim_len     = 8'd3;
        out_shift     = 5'd0;
        clear_status  = 1'b0;
        m_axis_tready = 1'b0;
        repeat (2) tick();
        chk("rst_tvalid", int'(m_axis_tvalid), 0);
        chk("rst_tdata", int'(m_axis_tdata), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_peak", int'(peak_abs), 0);
        chk("rst_level", int'(fifo_level), 0);
        resetn = 1'b1;
        enable = 1'b1;
        tick();

        // First-result latency: visible after the 4th edge from the last beat.
        for (int b = 0; b < 4; b++)
            drive(16'h0190, 1'b1);
        tick();
        tick();
        chk("lat_tvalid_e3", int'(m_axis_tvalid), 0);
        tick();
        chk("lat_tvalid_e4", int'(m_axis_tvalid), 1);
        chk("lat_tdata_e4", int'($signed(m_axis_tdata)), 3200);
        chk("lat_level_e4", int'(fifo_level), 1);
        exp_q.push_back(3200);
        drain(40);

        for (int v = 0; v < 8; v++) begin
            decim_len = 8'(vecs[v].dl);
            out_shift = 5'(vecs[v].sh);
            pulse_clear();
            m_axis_tready = 1'b1;
            for (int b = 0; b < vecs[v].nbeats; b++) begin
                drive(vecs[v].lane, 1'b1);
                if ((b + 1) % (vecs[v].dl + 1) == 0)
                    exp_q.push_back(vecs[v].exp_data);
            end
            drain(60);
            chk($sformatf("vec%0d_peak", v), int'(peak_abs), vecs[v].exp_peak);
            chk($sformatf("vec%0d_overflow", v), int'(overflow), 0);
        end

        // Overflow: 20 one-beat windows into a stalled 16-deep FIFO.
        m_axis_tready = 1'b0;
        decim_len     = 8'd0;
        out_shift     = 5'd0;
        pulse_clear();
        for (int i = 1; i <= 20; i++) begin
            drive(16'(i << 2), 1'b1);
            if (i <= 16)
                exp_q.push_back(8 * i);
        end
        repeat (6) tick();
        chk("ovf_level", int'(fifo_level), 16);
        chk("ovf_flag", int'(overflow), 1);
        chk("ovf_head", int'($signed(m_axis_tdata)), 8);
        chk("ovf_peak", int'(peak_abs), 128);
        pulse_clear();
        chk("ovf_cleared", int'(overflow), 0);
        chk("peak_cleared", int'(peak_abs), 0);
        // Push lands on a full FIFO in the same cycle as a pop: must be accepted.
        drive(16'(21 << 2), 1'b1);
        tick();
        tick();
        m_axis_tready = 1'b1;
        exp_q.push_back(168);
        tick();
        chk("fullpop_level", int'(fifo_level), 16);
        chk("fullpop_overflow", int'(overflow), 0);
        drain(60);
        chk("fullpop_peak", int'(peak_abs), 168);
        chk("fullpop_overflow_end", int'(overflow), 0);

        // Valid every other cycle: one word per 4 clocks.
        decim_len = 8'd1;
        pop_cyc.delete();
        for (int k = 0; k < 16; k++) begin
            drive(16'h0004, (k % 2) == 0);
            if (k % 4 == 2)
                exp_q.push_back(16);
        end
        drain(40);
        chk("gap_count", pop_cyc.size(), 4);
        if (pop_cyc.size() == 4) begin
            chk("gap_spacing_a", pop_cyc[1] - pop_cyc[0], 4);
            chk("gap_spacing_b", pop_cyc[3] - pop_cyc[2], 4);
        end

        // Window length changed mid-window only affects the next window.
        decim_len = 8'd3;
        drive(16'h0190, 1'b1);
        drive(16'h0190, 1'b1);
        drive(16'h0000, 1'b0);
        drive(16'h0000, 1'b0);
        decim_len = 8'd0;
        drive(16'h0190, 1'b1);
        drive(16'h0190, 1'b1);
        exp_q.push_back(3200);
        drive(16'h0190, 1'b1);
        exp_q.push_back(800);
        drive(16'h0190, 1'b1);
        exp_q.push_back(800);
        drain(40);

        // Dropping enable discards the partial window.
        decim_len = 8'd3;
        drive(16'h0190, 1'b1);
        drive(16'h0190, 1'b1);
        enable = 1'b0;
        tick();
        tick();
        enable = 1'b1;
        for (int b = 0; b < 4; b++)
            drive(16'h0190, 1'b1);
        exp_q.push_back(3200);
        drain(40);

        // Asynchronous reset mid-window empties the FIFO at once.
        m_axis_tready = 1'b0;
        decim_len     = 8'd0;
        drive(16'h0190, 1'b1);
        drive(16'h0190, 1'b1);
        repeat (4) tick();
        chk("prerst_level", int'(fifo_level), 2);
        decim_len = 8'd3;
        drive(16'h0190, 1'b1);
        drive(16'h0190, 1'b1);
        resetn = 1'b0;
        #1;
        chk("midrst_tvalid", int'(m_axis_tvalid), 0);
        chk("midrst_level", int'(fifo_level), 0);
        tick();
        resetn = 1'b1;
        tick();
        for (int b = 0; b < 4; b++)
            drive(16'h0190, 1'b1);
        exp_q.push_back(3200);
        drain(40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
